// File: rtl/axi_lite_arbiter_pkg.sv
// Shared types and constants for the two-to-one AXI4-Lite arbiter.
package axi_lite_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WREQ,
    WRESP
  } arb_state_e;

  typedef logic port_id_t;

  localparam port_id_t PORT_S0 = 1'b0;
  localparam port_id_t PORT_S1 = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite bundle used for both requester ports and the shared memory master port.
interface axi_lite_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  // Master drives requests and response-accepts; slave drives the rest.
  modport master (
    output araddr, arprot, arvalid, rready,
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_lite_arbiter_grant.sv
// Two-requester grant logic; round-robin pointer when ARB_ROUND_ROBIN_EN is defined,
// otherwise fixed priority with s1 over s0.
module arb_grant2
  import axi_lite_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
  port_id_t last;

  // Pointer starts at s1 so that s0 wins the first contended cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PORT_S1;
    end else if (update) begin
      last <= gnt[1];
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == PORT_S1) ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_rr_inputs;

  assign gnt = {req[1], req[0] & ~req[1]};
  assign unused_rr_inputs = ^{clk, rst, update};
`endif

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-to-one AXI4-Lite arbiter, one outstanding transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed s1-over-s0.
module axi_lite_arbiter
  import axi_lite_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                rst,
  axi_lite_arbiter_if.slave  s0,
  axi_lite_arbiter_if.slave  s1,
  axi_lite_arbiter_if.master m
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e        state;
  arb_state_e        state_next;
  port_id_t          gnt_id;
  port_id_t          grant_port;
  logic [1:0]        rd_req;
  logic [1:0]        wr_req;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              grant_fire;
  logic              grant_wr;
  logic              rready_sel;
  logic              bready_sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_prot;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        prot_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              arvalid_q;
  logic              awvalid_q;
  logic              wvalid_q;

  // A write needs AW and W together; arbitration only happens in IDLE outside reset.
  assign rd_req     = {s1.arvalid, s0.arvalid};
  assign wr_req     = {s1.awvalid & s1.wvalid, s0.awvalid & s0.wvalid};
  assign req        = (rd_req | wr_req) & {2{(state == IDLE) && !rst}};
  assign grant_fire = |gnt;
  assign grant_port = gnt[1];
  assign grant_wr   = (grant_port == PORT_S1) ? wr_req[1] : wr_req[0];
  assign rready_sel = (gnt_id == PORT_S1) ? s1.rready : s0.rready;
  assign bready_sel = (gnt_id == PORT_S1) ? s1.bready : s0.bready;

  arb_grant2 u_grant (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (grant_fire),
    .gnt    (gnt)
  );

  always_comb begin
    sel_wdata = (grant_port == PORT_S1) ? s1.wdata : s0.wdata;
    sel_wstrb = (grant_port == PORT_S1) ? s1.wstrb : s0.wstrb;
    if (grant_wr) begin
      sel_addr = (grant_port == PORT_S1) ? s1.awaddr : s0.awaddr;
      sel_prot = (grant_port == PORT_S1) ? s1.awprot : s0.awprot;
    end else begin
      sel_addr = (grant_port == PORT_S1) ? s1.araddr : s0.araddr;
      sel_prot = (grant_port == PORT_S1) ? s1.arprot : s0.arprot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Master-side payload and valids are registered at grant and held until handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_id    <= PORT_S0;
      addr_q    <= '0;
      prot_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      if (grant_fire) begin
        gnt_id <= grant_port;
        addr_q <= sel_addr;
        prot_q <= sel_prot;
        if (grant_wr) begin
          wdata_q   <= sel_wdata;
          wstrb_q   <= sel_wstrb;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
        end else begin
          arvalid_q <= 1'b1;
        end
      end
      if (arvalid_q && m.arready) begin
        arvalid_q <= 1'b0;
      end
      if (awvalid_q && m.awready) begin
        awvalid_q <= 1'b0;
      end
      if (wvalid_q && m.wready) begin
        wvalid_q <= 1'b0;
      end
    end
  end

  assign m.araddr  = addr_q;
  assign m.arprot  = prot_q;
  assign m.arvalid = arvalid_q;
  assign m.awaddr  = addr_q;
  assign m.awprot  = prot_q;
  assign m.awvalid = awvalid_q;
  assign m.wdata   = wdata_q;
  assign m.wstrb   = wstrb_q;
  assign m.wvalid  = wvalid_q;

  // Slave-side handshakes and response routing; the non-granted port stays all zero.
  always_comb begin
    state_next = state;
    s0.arready = 1'b0;
    s0.awready = 1'b0;
    s0.wready  = 1'b0;
    s0.rvalid  = 1'b0;
    s0.rdata   = '0;
    s0.rresp   = '0;
    s0.bvalid  = 1'b0;
    s0.bresp   = '0;
    s1.arready = 1'b0;
    s1.awready = 1'b0;
    s1.wready  = 1'b0;
    s1.rvalid  = 1'b0;
    s1.rdata   = '0;
    s1.rresp   = '0;
    s1.bvalid  = 1'b0;
    s1.bresp   = '0;
    m.rready   = 1'b0;
    m.bready   = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (grant_fire) begin
            state_next = grant_wr ? WREQ : RADDR;
            if (grant_port == PORT_S1) begin
              s1.arready = !grant_wr;
              s1.awready = grant_wr;
              s1.wready  = grant_wr;
            end else begin
              s0.arready = !grant_wr;
              s0.awready = grant_wr;
              s0.wready  = grant_wr;
            end
          end
        end
        RADDR: begin
          if (m.arready) begin
            state_next = RDATA;
          end
        end
        RDATA: begin
          m.rready = rready_sel;
          if (gnt_id == PORT_S1) begin
            s1.rvalid = m.rvalid;
            s1.rdata  = m.rdata;
            s1.rresp  = m.rresp;
          end else begin
            s0.rvalid = m.rvalid;
            s0.rdata  = m.rdata;
            s0.rresp  = m.rresp;
          end
          if (m.rvalid && rready_sel) begin
            state_next = IDLE;
          end
        end
        WREQ: begin
          if ((!awvalid_q || m.awready) && (!wvalid_q || m.wready)) begin
            state_next = WRESP;
          end
        end
        WRESP: begin
          m.bready = bready_sel;
          if (gnt_id == PORT_S1) begin
            s1.bvalid = m.bvalid;
            s1.bresp  = m.bresp;
          end else begin
            s0.bvalid = m.bvalid;
            s0.bresp  = m.bresp;
          end
          if (m.bvalid && bready_sel) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed self-checking bench for axi_lite_arbiter; expectations follow ARB_ROUND_ROBIN_EN.
module tb_axi_lite_arbiter;
  import axi_lite_arbiter_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef ARB_ROUND_ROBIN_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   assert_count = 0;
  int   fail_count   = 0;

  always #5 clk = ~clk;

  axi_lite_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s0_bus ();
  axi_lite_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s1_bus ();
  axi_lite_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_bus ();

  axi_lite_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .s0  (s0_bus),
    .s1  (s1_bus),
    .m   (m_bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [5:0] slaveReadies();
    return {s1_bus.awready, s1_bus.wready, s1_bus.arready,
            s0_bus.awready, s0_bus.wready, s0_bus.arready};
  endfunction

  function automatic logic [3:0] slaveValids();
    return {s1_bus.bvalid, s1_bus.rvalid, s0_bus.bvalid, s0_bus.rvalid};
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    s0_bus.araddr = '0; s0_bus.arprot = '0; s0_bus.arvalid = 1'b0; s0_bus.rready = 1'b0;
    s0_bus.awaddr = '0; s0_bus.awprot = '0; s0_bus.awvalid = 1'b0;
    s0_bus.wdata = '0; s0_bus.wstrb = '0; s0_bus.wvalid = 1'b0; s0_bus.bready = 1'b0;
    s1_bus.araddr = '0; s1_bus.arprot = '0; s1_bus.arvalid = 1'b0; s1_bus.rready = 1'b0;
    s1_bus.awaddr = '0; s1_bus.awprot = '0; s1_bus.awvalid = 1'b0;
    s1_bus.wdata = '0; s1_bus.wstrb = '0; s1_bus.wvalid = 1'b0; s1_bus.bready = 1'b0;
    m_bus.arready = 1'b0; m_bus.rdata = '0; m_bus.rresp = '0; m_bus.rvalid = 1'b0;
    m_bus.awready = 1'b0; m_bus.wready = 1'b0; m_bus.bresp = '0; m_bus.bvalid = 1'b0;
  endtask

  task automatic resetDut();
    clearInputs();
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  task automatic setMasterZeroWait(input logic [31:0] rdata);
    m_bus.arready = 1'b1; m_bus.awready = 1'b1; m_bus.wready = 1'b1;
    m_bus.rvalid = 1'b1; m_bus.rdata = rdata; m_bus.rresp = RESP_OKAY;
    m_bus.bvalid = 1'b1; m_bus.bresp = RESP_OKAY;
    s0_bus.rready = 1'b1; s0_bus.bready = 1'b1;
    s1_bus.rready = 1'b1; s1_bus.bready = 1'b1;
  endtask

  // Port 0 reads carry instruction prot (3'b100), port 1 carries 3'b001.
  task automatic applyStimulus(input int port, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb, input bit on);
    if (port == 0) begin
      if (wr) begin
        s0_bus.awaddr = addr; s0_bus.awprot = 3'b100; s0_bus.awvalid = on;
        s0_bus.wdata = data; s0_bus.wstrb = strb; s0_bus.wvalid = on;
      end else begin
        s0_bus.araddr = addr; s0_bus.arprot = 3'b100; s0_bus.arvalid = on;
      end
    end else begin
      if (wr) begin
        s1_bus.awaddr = addr; s1_bus.awprot = 3'b001; s1_bus.awvalid = on;
        s1_bus.wdata = data; s1_bus.wstrb = strb; s1_bus.wvalid = on;
      end else begin
        s1_bus.araddr = addr; s1_bus.arprot = 3'b001; s1_bus.arvalid = on;
      end
    end
  endtask

  // Zero-wait transaction from the IDLE grant cycle through the response cycle.
  task automatic runTxn(input int port, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata);
    logic [5:0]  exp_rdy;
    logic [3:0]  exp_vld;
    logic [63:0] exp_rd;
    exp_rdy = (wr ? 6'b000110 : 6'b000001) << (port * 3);
    exp_vld = (wr ? 4'b0010 : 4'b0001) << (port * 2);
    exp_rd  = (port == 1) ? {rdata, 32'h0} : {32'h0, rdata};
    @(negedge clk);
    checkOutput("grant_readies", slaveReadies(), exp_rdy);
    nextCycle();
    applyStimulus(port, wr, addr, data, 4'hF, 1'b0);
    @(negedge clk);
    checkOutput("one_txn", {m_bus.arvalid, m_bus.awvalid, m_bus.wvalid}, wr ? 3'b011 : 3'b100);
    checkOutput("m_addr", wr ? m_bus.awaddr : m_bus.araddr, addr);
    if (wr) checkOutput("m_wdata", {m_bus.wstrb, m_bus.wdata}, {4'hF, data});
    checkOutput("no_grant_busy", slaveReadies(), 6'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("resp_route", slaveValids(), exp_vld);
    if (!wr) checkOutput("rdata_route", {s1_bus.rdata, s0_bus.rdata}, exp_rd);
    nextCycle();
  endtask

  initial begin
    int nxt;
    clearInputs();
    rst = 1'b1;

    // Reset state, with a pending request that must not be granted.
    s0_bus.arvalid = 1'b1;
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_m_ctrl", {m_bus.arvalid, m_bus.awvalid, m_bus.wvalid, m_bus.rready, m_bus.bready}, 5'b0);
    checkOutput("rst_m_addr", {m_bus.araddr, m_bus.awaddr}, 64'h0);
    checkOutput("rst_m_wdata", {m_bus.wstrb, m_bus.wdata}, 36'h0);
    checkOutput("rst_readies", slaveReadies(), 6'b0);
    checkOutput("rst_valids", slaveValids(), 4'b0);
    nextCycle();
    clearInputs();
    rst = 1'b0;

    // s0 read, one RADDR stall, three wait cycles before data.
    applyStimulus(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("rd_grant", slaveReadies(), 6'b000001);
    nextCycle();
    applyStimulus(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("rd_araddr", {m_bus.arvalid, m_bus.arprot, m_bus.araddr}, {1'b1, 3'b100, 32'h0000_1000});
    nextCycle();
    m_bus.arready = 1'b1;
    @(negedge clk);
    checkOutput("rd_arvalid_hold", m_bus.arvalid, 1'b1);
    nextCycle();
    m_bus.arready = 1'b0;
    s0_bus.rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rd_wait", {m_bus.arvalid, s0_bus.rvalid, m_bus.rready}, 3'b001);
      nextCycle();
    end
    m_bus.rvalid = 1'b1; m_bus.rdata = 32'hDEAD_BEEF; m_bus.rresp = RESP_OKAY;
    @(negedge clk);
    checkOutput("rd_data", {s0_bus.rvalid, s0_bus.rresp, s0_bus.rdata}, {1'b1, RESP_OKAY, 32'hDEAD_BEEF});
    checkOutput("rd_s1_quiet", {s1_bus.rvalid, s1_bus.bvalid, s1_bus.rresp, s1_bus.rdata}, 36'h0);
    checkOutput("rd_m_rready", m_bus.rready, 1'b1);
    nextCycle();
    m_bus.rvalid = 1'b0;
    @(negedge clk);
    checkOutput("rd_back_idle", {slaveValids(), m_bus.arvalid, m_bus.rready}, 6'b0);

    // Simultaneous s0 read and s1 write after reset.
    resetDut();
    setMasterZeroWait(32'hCAFE_F00D);
    applyStimulus(0, 1'b0, 32'h0000_3000, 32'h0, 4'h0, 1'b1);
    applyStimulus(1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF, 1'b1);
`ifdef ARB_ROUND_ROBIN_EN
    runTxn(0, 1'b0, 32'h0000_3000, 32'h0, 32'hCAFE_F00D);
    runTxn(1, 1'b1, 32'h0000_2000, 32'h1234_5678, 32'h0);
`else
    runTxn(1, 1'b1, 32'h0000_2000, 32'h1234_5678, 32'h0);
    runTxn(0, 1'b0, 32'h0000_3000, 32'h0, 32'hCAFE_F00D);
`endif
    clearInputs();
    nextCycle();

    // s1 write: AW accepted at T+1, W only at T+4, DECERR response.
    m_bus.awready = 1'b1; m_bus.bvalid = 1'b1; m_bus.bresp = RESP_DECERR; s1_bus.bready = 1'b1;
    applyStimulus(1, 1'b1, 32'h0000_4004, 32'hA5A5_0001, 4'h3, 1'b1);
    @(negedge clk);
    checkOutput("wr_grant", slaveReadies(), 6'b110000);
    nextCycle();
    applyStimulus(1, 1'b1, 32'h0000_4004, 32'hA5A5_0001, 4'h3, 1'b0);
    @(negedge clk);
    checkOutput("wr_t1", {m_bus.awvalid, m_bus.wvalid, m_bus.wstrb, m_bus.awprot}, {2'b11, 4'h3, 3'b001});
    for (int t = 2; t <= 4; t++) begin
      nextCycle();
      m_bus.wready = (t == 4);
      @(negedge clk);
      checkOutput("wr_w_pending", {m_bus.awvalid, m_bus.wvalid, s1_bus.bvalid, m_bus.bready}, 4'b0100);
    end
    nextCycle();
    m_bus.wready = 1'b0;
    @(negedge clk);
    checkOutput("wr_resp", {m_bus.awvalid, m_bus.wvalid, s1_bus.bvalid, s1_bus.bresp, m_bus.bready, s0_bus.bvalid},
                {2'b00, 1'b1, RESP_DECERR, 1'b1, 1'b0});
    nextCycle();
    clearInputs();
    @(negedge clk);
    checkOutput("wr_back_idle", slaveValids(), 4'b0);
    nextCycle();

    // s1 read with SLVERR and a stalled rready.
    m_bus.arready = 1'b1;
    applyStimulus(1, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 1'b1);
    nextCycle();
    applyStimulus(1, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 1'b0);
    nextCycle();
    m_bus.rvalid = 1'b1; m_bus.rresp = RESP_SLVERR; m_bus.rdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("slverr_stall", {s1_bus.rvalid, s1_bus.rresp, m_bus.rready, s0_bus.rvalid}, {1'b1, RESP_SLVERR, 2'b00});
      nextCycle();
    end
    s1_bus.rready = 1'b1;
    @(negedge clk);
    checkOutput("slverr_accept", {s1_bus.rvalid, s1_bus.rresp, s1_bus.rdata, m_bus.rready},
                {1'b1, RESP_SLVERR, 32'h0BAD_0BAD, 1'b1});
    nextCycle();
    @(negedge clk);
    checkOutput("slverr_done", s1_bus.rvalid, 1'b0);
    clearInputs();
    nextCycle();

    // Reset while in RDATA abandons the read; a fresh read then completes.
    m_bus.arready = 1'b1;
    applyStimulus(0, 1'b0, 32'h0000_6000, 32'h0, 4'h0, 1'b1);
    nextCycle();
    applyStimulus(0, 1'b0, 32'h0000_6000, 32'h0, 4'h0, 1'b0);
    nextCycle();
    m_bus.rvalid = 1'b1;
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_slave", {slaveValids(), slaveReadies()}, 10'b0);
    checkOutput("mid_rst_master", {m_bus.arvalid, m_bus.awvalid, m_bus.wvalid, m_bus.rready, m_bus.bready}, 5'b0);
    nextCycle();
    clearInputs();
    setMasterZeroWait(32'h600D_600D);
    applyStimulus(0, 1'b0, 32'h0000_6100, 32'h0, 4'h0, 1'b1);
    runTxn(0, 1'b0, 32'h0000_6100, 32'h0, 32'h600D_600D);

    // Both ports requesting continuously: a grant every third cycle.
    resetDut();
    setMasterZeroWait(32'h0000_0077);
    applyStimulus(0, 1'b0, 32'h0000_7000, 32'h0, 4'h0, 1'b1);
    applyStimulus(1, 1'b1, 32'h0000_7100, 32'h0000_0099, 4'hF, 1'b1);
    nxt = 1 - RR;
    for (int c = 0; c < 99; c++) begin
      @(negedge clk);
      if (c % 3 == 0) begin
        checkOutput("b2b_grant", slaveReadies(), (nxt == 0) ? 6'b000001 : 6'b110000);
        nxt = nxt ^ RR;
      end else begin
        checkOutput("b2b_no_grant", slaveReadies(), 6'b0);
      end
      checkOutput("b2b_single", {m_bus.arvalid & m_bus.awvalid}, 1'b0);
      nextCycle();
    end

    clearInputs();
    nextCycle();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
